// File: rtl/d_write_buffer.sv
// d_write_buffer: posted-write FIFO between the D-cache and the sram-to-AXI bridge.
// Define WBUF_RAW_BYPASS_EN to let reads overtake non-matching buffered writes.
module d_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        mem_data_req,
    output logic        mem_data_wr,
    output logic [1:0]  mem_data_size,
    output logic [31:0] mem_data_addr,
    output logic [31:0] mem_data_wdata,
    input  logic [31:0] mem_data_rdata,
    input  logic        mem_data_addr_ok,
    input  logic        mem_data_data_ok,
    output logic        wbuf_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      ent_addr_q  [DEPTH];
    logic [1:0]       ent_size_q  [DEPTH];
    logic [31:0]      ent_wdata_q [DEPTH];
    logic [DEPTH-1:0] ent_valid_q;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [31:0] rd_addr_q, rd_addr_d;
    logic [1:0]  rd_size_q, rd_size_d;
    logic        wr_ack_q, wr_ack_d;

    logic full;
    logic empty;
    logic rd_busy;
    logic hazard_free;
    logic rd_elig;
    logic push;
    logic pop;
    logic rd_done;

    assign full    = (count_q == CNT_FULL);
    assign empty   = ~|ent_valid_q;
    assign rd_busy = (state_q == S_RD_REQ) | (state_q == S_RD_WAIT);

`ifdef WBUF_RAW_BYPASS_EN
    // Word-granular match: any byte of a buffered word blocks the read.
    logic raw_hit;
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i] && (ent_addr_q[i][31:2] == cpu_data_addr[31:2]))
                raw_hit = 1'b1;
        end
    end
    assign hazard_free = ~raw_hit;
`else
    assign hazard_free = empty;
`endif

    assign push    = cpu_data_req & cpu_data_wr & ~full & ~rd_busy;
    assign rd_elig = cpu_data_req & ~cpu_data_wr & (state_q == S_IDLE)
                   & hazard_free;

    assign cpu_data_addr_ok = resetn & (push | rd_elig);
    assign cpu_data_data_ok = wr_ack_q | rd_done;
    assign wbuf_empty       = empty & (state_q == S_IDLE);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rd_addr_d = rd_addr_q;
        rd_size_d = rd_size_q;
        wr_ack_d  = push;
        if (push)
            tail_d = tail_q + PTR_ONE;
        if (pop)
            head_d = head_q + PTR_ONE;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;
        if (rd_elig) begin
            rd_addr_d = cpu_data_addr;
            rd_size_d = cpu_data_size;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            rd_size_q <= '0;
            wr_ack_q  <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            rd_size_q <= rd_size_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i]  <= '0;
                ent_size_q[i]  <= '0;
                ent_wdata_q[i] <= '0;
            end
            ent_valid_q <= '0;
        end else begin
            if (pop)
                ent_valid_q[head_q] <= 1'b0;
            if (push) begin
                ent_valid_q[tail_q] <= 1'b1;
                ent_addr_q[tail_q]  <= cpu_data_addr;
                ent_size_q[tail_q]  <= cpu_data_size;
                ent_wdata_q[tail_q] <= cpu_data_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Reads win over drain in IDLE so a refill is never queued behind write-backs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_elig)
                    state_d = S_RD_REQ;
                else if (!empty)
                    state_d = S_WR_REQ;
            end
            S_RD_REQ: begin
                if (mem_data_addr_ok)
                    state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_data_data_ok)
                    state_d = S_IDLE;
            end
            S_WR_REQ: begin
                if (mem_data_addr_ok)
                    state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mem_data_data_ok)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_data_req   = 1'b0;
        mem_data_wr    = 1'b0;
        mem_data_size  = '0;
        mem_data_addr  = '0;
        mem_data_wdata = '0;
        cpu_data_rdata = '0;
        rd_done        = 1'b0;
        pop            = 1'b0;
        unique case (state_q)
            S_RD_REQ: begin
                mem_data_req  = 1'b1;
                mem_data_size = rd_size_q;
                mem_data_addr = rd_addr_q;
            end
            S_RD_WAIT: begin
                if (mem_data_data_ok) begin
                    rd_done        = 1'b1;
                    cpu_data_rdata = mem_data_rdata;
                end
            end
            S_WR_REQ: begin
                mem_data_req   = 1'b1;
                mem_data_wr    = 1'b1;
                mem_data_size  = ent_size_q[head_q];
                mem_data_addr  = ent_addr_q[head_q];
                mem_data_wdata = ent_wdata_q[head_q];
            end
            S_WR_WAIT: begin
                pop = mem_data_data_ok;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_d_write_buffer.sv
// tb_d_write_buffer: cycle vectors plus sequences with a stallable memory model.
// Ordering expectations follow WBUF_RAW_BYPASS_EN when it is defined.
module tb_d_write_buffer;

`ifdef WBUF_RAW_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_data_req;
    logic        cpu_data_wr;
    logic [1:0]  cpu_data_size;
    logic [31:0] cpu_data_addr;
    logic [31:0] cpu_data_wdata;
    logic [31:0] cpu_data_rdata;
    logic        cpu_data_addr_ok;
    logic        cpu_data_data_ok;
    logic        mem_data_req;
    logic        mem_data_wr;
    logic [1:0]  mem_data_size;
    logic [31:0] mem_data_addr;
    logic [31:0] mem_data_wdata;
    logic [31:0] mem_data_rdata;
    logic        mem_data_addr_ok;
    logic        mem_data_data_ok;
    logic        wbuf_empty;

    always #5 clk = ~clk;

    d_write_buffer #(.DEPTH(4)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .cpu_data_req     (cpu_data_req),
        .cpu_data_wr      (cpu_data_wr),
        .cpu_data_size    (cpu_data_size),
        .cpu_data_addr    (cpu_data_addr),
        .cpu_data_wdata   (cpu_data_wdata),
        .cpu_data_rdata   (cpu_data_rdata),
        .cpu_data_addr_ok (cpu_data_addr_ok),
        .cpu_data_data_ok (cpu_data_data_ok),
        .mem_data_req     (mem_data_req),
        .mem_data_wr      (mem_data_wr),
        .mem_data_size    (mem_data_size),
        .mem_data_addr    (mem_data_addr),
        .mem_data_wdata   (mem_data_wdata),
        .mem_data_rdata   (mem_data_rdata),
        .mem_data_addr_ok (mem_data_addr_ok),
        .mem_data_data_ok (mem_data_data_ok),
        .wbuf_empty       (wbuf_empty)
    );

    typedef struct {
        logic        rq, wr;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        logic        mao, mdo;
        logic [31:0] mrd;
        logic        eao, edo;
        logic [31:0] erd;
        logic        emr, emw;
        logic [1:0]  ems;
        logic [31:0] ema, emwd;
        logic        ee;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    vec_t tbl [15];
    txn_t log_q [$];

    int checks = 0;
    int errors = 0;

    bit          auto_en = 1'b0;
    bit          stall = 1'b0;
    bit          hold_data = 1'b0;
    bit          pend = 1'b0;
    bit          pend_rd = 1'b0;
    logic [31:0] pend_addr = '0;

    function automatic vec_t v(
        input logic rq, wr, input logic [1:0] sz,
        input logic [31:0] a, wd,
        input logic mao, mdo, input logic [31:0] mrd,
        input logic eao, edo, input logic [31:0] erd,
        input logic emr, emw, input logic [1:0] ems,
        input logic [31:0] ema, emwd, input logic ee);
        vec_t t;
        t.rq = rq; t.wr = wr; t.sz = sz; t.a = a; t.wd = wd;
        t.mao = mao; t.mdo = mdo; t.mrd = mrd;
        t.eao = eao; t.edo = edo; t.erd = erd;
        t.emr = emr; t.emw = emw; t.ems = ems;
        t.ema = ema; t.emwd = emwd; t.ee = ee;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: accepts when not stalled, answers data_ok the next cycle.
    task automatic tick();
        @(negedge clk);
        if (auto_en) begin
            mem_data_addr_ok = 1'b0;
            mem_data_data_ok = 1'b0;
            mem_data_rdata   = '0;
            if (pend) begin
                if (!hold_data) begin
                    mem_data_data_ok = 1'b1;
                    mem_data_rdata = pend_rd ? (pend_addr ^ 32'hA5A5_0000) : '0;
                    pend = 1'b0;
                end
            end else if (mem_data_req && !stall) begin
                mem_data_addr_ok = 1'b1;
                pend      = 1'b1;
                pend_rd   = !mem_data_wr;
                pend_addr = mem_data_addr;
                log_q.push_back('{mem_data_wr, mem_data_addr, mem_data_wdata});
            end
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        cpu_data_req   = 1'b1;
        cpu_data_wr    = 1'b1;
        cpu_data_size  = 2'd2;
        cpu_data_addr  = a;
        cpu_data_wdata = d;
        #1;
        while (!cpu_data_addr_ok && n < 100) begin
            tick(); #1; n++;
        end
        chk("wr accept", cpu_data_addr_ok, 1'b1);
        tick();
        cpu_data_req = 1'b0;
        #1;
        chk("wr data_ok", cpu_data_data_ok, 1'b1);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d,
                            output int acc_log, output bit acc_pend);
        int n;
        n = 0;
        cpu_data_req  = 1'b1;
        cpu_data_wr   = 1'b0;
        cpu_data_size = 2'd2;
        cpu_data_addr = a;
        #1;
        while (!cpu_data_addr_ok && n < 100) begin
            tick(); #1; n++;
        end
        chk("rd accept", cpu_data_addr_ok, 1'b1);
        acc_log  = log_q.size();
        acc_pend = pend;
        tick();
        cpu_data_req = 1'b0;
        #1;
        n = 0;
        while (!cpu_data_data_ok && n < 100) begin
            tick(); #1; n++;
        end
        chk("rd data_ok", cpu_data_data_ok, 1'b1);
        d = cpu_data_rdata;
    endtask

    task automatic drain();
        int n;
        n = 0;
        tick(); #1;
        while (!wbuf_empty && n < 200) begin
            tick(); #1; n++;
        end
        chk("drain", wbuf_empty, 1'b1);
    endtask

    task automatic chk_log(input string nm, input int k, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (k < log_q.size())
            chk(nm, {log_q[k].wr, log_q[k].addr, log_q[k].data}, {wr, a, d});
        else
            chk(nm, 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [102:0] act, exp;
        logic [31:0]  rd;
        int           acc_log, acc, nreq;
        bit           acc_pend, held;

        tbl[0]  = v(1,1,1,32'h1000_0040,32'hDEAD_BEEF, 0,0,0, 1,0,0, 0,0,0,0,0, 1);
        tbl[1]  = v(0,0,0,0,0, 0,0,0, 0,1,0, 0,0,0,0,0, 0);
        tbl[2]  = v(0,0,0,0,0, 1,0,0, 0,0,0,
                    1,1,1,32'h1000_0040,32'hDEAD_BEEF, 0);
        tbl[3]  = v(0,0,0,0,0, 0,1,0, 0,0,0, 0,0,0,0,0, 0);
        tbl[4]  = v(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 1);
        tbl[5]  = v(1,0,2,32'h2000_0004,0, 0,0,0, 1,0,0, 0,0,0,0,0, 1);
        tbl[6]  = v(0,0,0,0,0, 0,0,0, 0,0,0, 1,0,2,32'h2000_0004,0, 0);
        tbl[7]  = v(0,0,0,0,0, 1,0,0, 0,0,0, 1,0,2,32'h2000_0004,0, 0);
        tbl[8]  = v(1,1,2,32'h300,32'h55, 0,0,32'h1234_5678, 0,0,0,
                    0,0,0,0,0, 0);
        tbl[9]  = v(1,1,2,32'h300,32'h55, 0,1,32'hCAFE_F00D, 0,1,32'hCAFE_F00D,
                    0,0,0,0,0, 0);
        tbl[10] = v(1,1,2,32'h300,32'h55, 0,0,32'hFFFF_FFFF, 1,0,0,
                    0,0,0,0,0, 1);
        tbl[11] = v(0,0,0,0,0, 0,0,0, 0,1,0, 0,0,0,0,0, 0);
        tbl[12] = v(0,0,0,0,0, 1,0,0, 0,0,0, 1,1,2,32'h300,32'h55, 0);
        tbl[13] = v(0,0,0,0,0, 0,1,0, 0,0,0, 0,0,0,0,0, 0);
        tbl[14] = v(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 1);

        resetn = 1'b0;
        cpu_data_req = 0; cpu_data_wr = 0; cpu_data_size = 0;
        cpu_data_addr = 0; cpu_data_wdata = 0;
        mem_data_rdata = 0; mem_data_addr_ok = 0; mem_data_data_ok = 0;
        repeat (2) tick();
        #1;
        chk("reset outputs",
            {cpu_data_addr_ok, cpu_data_data_ok, cpu_data_rdata, mem_data_req,
             mem_data_wr, mem_data_size, mem_data_addr, mem_data_wdata, wbuf_empty},
            {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0, 1'b1});
        tick();
        resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            tick();
            cpu_data_req = tbl[i].rq;  cpu_data_wr = tbl[i].wr;
            cpu_data_size = tbl[i].sz; cpu_data_addr = tbl[i].a;
            cpu_data_wdata = tbl[i].wd;
            mem_data_addr_ok = tbl[i].mao; mem_data_data_ok = tbl[i].mdo;
            mem_data_rdata = tbl[i].mrd;
            #1;
            act = {cpu_data_addr_ok, cpu_data_data_ok, cpu_data_rdata,
                   mem_data_req, wbuf_empty,
                   tbl[i].emr ? mem_data_wr : 1'b0,
                   tbl[i].emr ? mem_data_size : 2'b0,
                   tbl[i].emr ? mem_data_addr : 32'h0,
                   (tbl[i].emr && tbl[i].emw) ? mem_data_wdata : 32'h0};
            exp = {tbl[i].eao, tbl[i].edo, tbl[i].erd, tbl[i].emr, tbl[i].ee,
                   tbl[i].emw, tbl[i].ems, tbl[i].ema, tbl[i].emwd};
            chk($sformatf("vec[%0d]", i), act, exp);
        end
        cpu_data_req = 0;
        mem_data_addr_ok = 0; mem_data_data_ok = 0; mem_data_rdata = 0;
        auto_en = 1'b1;

        // Fill to DEPTH with downstream stalled; fifth write waits for a pop.
        log_q.delete();
        stall = 1'b1;
        for (int k = 0; k < 4; k++)
            cpu_write(32'h1000 + 32'(k * 4), 32'hF0 + 32'(k));
        cpu_data_req = 1'b1; cpu_data_wr = 1'b1;
        cpu_data_addr = 32'h1010; cpu_data_wdata = 32'hF4;
        held = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (cpu_data_addr_ok) held = 1'b0;
            tick(); #1;
        end
        chk("full holds addr_ok", held, 1'b1);
        stall = 1'b0;
        acc = 0;
        while (!cpu_data_addr_ok && acc < 20) begin
            tick(); #1; acc++;
        end
        chk("accept after pop latency", acc, 3);
        chk("accept after pop log", log_q.size(), 1);
        tick();
        cpu_data_req = 1'b0;
        #1;
        chk("fifth data_ok", cpu_data_data_ok, 1'b1);
        drain();
        chk("fill count", log_q.size(), 5);
        for (int k = 0; k < 5; k++)
            chk_log("fill order", k, 1'b1, 32'h1000 + 32'(k * 4), 32'hF0 + 32'(k));

        // Push and pop on the same edge at count 2.
        log_q.delete();
        stall = 1'b1;
        cpu_write(32'h2000, 32'hA0);
        cpu_write(32'h2004, 32'hA1);
        stall = 1'b0;
        tick(); tick();
        cpu_write(32'h2008, 32'hA2);
        stall = 1'b1;
        acc = 0;
        cpu_data_req = 1'b1; cpu_data_wr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cpu_data_addr  = 32'h200C + 32'(k * 4);
            cpu_data_wdata = 32'hA3 + 32'(k);
            #1;
            if (!cpu_data_addr_ok) break;
            acc++;
            tick();
        end
        chk("room after push+pop", acc, 2);
        cpu_data_req = 1'b0;
        stall = 1'b0;
        drain();
        chk("push+pop count", log_q.size(), 5);
        for (int k = 0; k < 5; k++)
            chk_log("push+pop order", k, 1'b1, 32'h2000 + 32'(k * 4), 32'hA0 + 32'(k));

        // Ten writes wrap the pointers twice.
        log_q.delete();
        for (int k = 0; k < 10; k++)
            cpu_write(32'h3000 + 32'(k * 4), 32'hB000 + 32'(k));
        drain();
        chk("wrap count", log_q.size(), 10);
        for (int k = 0; k < 10; k++)
            chk_log("wrap order", k, 1'b1, 32'h3000 + 32'(k * 4), 32'hB000 + 32'(k));

        // Non-matching read behind a stalled write.
        log_q.delete();
        stall = 1'b1;
        cpu_write(32'h100, 32'h11);
        cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_addr = 32'h200;
        #1;
        chk("read 0x200 early accept", cpu_data_addr_ok, BYPASS);
        stall = 1'b0;
        cpu_read(32'h200, rd, acc_log, acc_pend);
        chk("read 0x200 data", rd, 32'hA5A5_0200);
        drain();
        chk("read 0x200 txn count", log_q.size(), 2);
        if (BYPASS) begin
            chk_log("bypass read first", 0, 1'b0, 32'h200, 32'h0);
            chk_log("bypass write second", 1, 1'b1, 32'h100, 32'h11);
        end else begin
            chk_log("write first", 0, 1'b1, 32'h100, 32'h11);
            chk_log("read second", 1, 1'b0, 32'h200, 32'h0);
        end

        // Matching read must wait for the write's data_ok.
        log_q.delete();
        stall = 1'b1;
        cpu_write(32'h100, 32'h22);
        cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_addr = 32'h100;
        held = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (cpu_data_addr_ok) held = 1'b0;
            tick(); #1;
        end
        chk("raw read held", held, 1'b1);
        stall = 1'b0;
        cpu_read(32'h100, rd, acc_log, acc_pend);
        chk("raw accept after write", {acc_log[7:0], acc_pend}, {8'd1, 1'b0});
        chk("raw read data", rd, 32'hA5A5_0100);
        chk_log("raw write first", 0, 1'b1, 32'h100, 32'h22);
        drain();

        // Reset in WR_WAIT with three entries buffered.
        log_q.delete();
        stall = 1'b1;
        for (int k = 0; k < 3; k++)
            cpu_write(32'h4000 + 32'(k * 4), 32'hC0 + 32'(k));
        hold_data = 1'b1;
        stall = 1'b0;
        tick(); tick();
        cpu_data_req = 1'b1; cpu_data_wr = 1'b1; cpu_data_addr = 32'hBAD0;
        resetn = 1'b0;
        #1;
        chk("mid-reset outputs",
            {cpu_data_addr_ok, cpu_data_data_ok, cpu_data_rdata, mem_data_req,
             mem_data_wr, mem_data_size, mem_data_addr, mem_data_wdata, wbuf_empty},
            {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b0, 32'h0, 32'h0, 1'b1});
        cpu_data_req = 1'b0;
        pend = 1'b0;
        hold_data = 1'b0;
        log_q.delete();
        tick(); tick();
        resetn = 1'b1;
        nreq = 0;
        for (int k = 0; k < 20; k++) begin
            tick(); #1;
            if (mem_data_req) nreq++;
        end
        chk("no stale requests", nreq, 0);
        chk("no stale writes", log_q.size(), 0);
        chk("empty after reset", wbuf_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d_write_buffer.md
Name: d_write_buffer

Overview:
- Posted-write FIFO between the data cache's memory-side port and the sram-like-to-AXI bridge.
- Accepts write-backs from the cache and acknowledges them quickly, so a dirty-line eviction does not stall the refill read.
- Drains buffered writes to the bridge one at a time and passes reads through.
- Enforces read-after-write ordering against buffered entries.

Parameters:
- DEPTH, 4: number of buffered write entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH): pointer width; localparam, not overridable.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- cpu_data_req  in  1  upstream request; held until cpu_data_addr_ok
- cpu_data_wr  in  1  1 = write, 0 = read
- cpu_data_size  in  2  byte size code: 0 = byte, 1 = half, 2 = word
- cpu_data_addr  in  32  request address
- cpu_data_wdata  in  32  write data
- cpu_data_rdata  out  32  read data
- cpu_data_addr_ok  out  1  request accepted this cycle
- cpu_data_data_ok  out  1  request completed this cycle
- mem_data_req  out  1  downstream request
- mem_data_wr  out  1  downstream write flag
- mem_data_size  out  2  downstream size
- mem_data_addr  out  32  downstream address
- mem_data_wdata  out  32  downstream write data
- mem_data_rdata  in  32  downstream read data
- mem_data_addr_ok  in  1  downstream accepted the address
- mem_data_data_ok  in  1  downstream completed the transfer
- wbuf_empty  out  1  no buffered writes and downstream FSM in IDLE

Behaviour:
- Storage: DEPTH entries of {addr[31:0], size[1:0], wdata[31:0]}, each with a valid bit; head/tail pointers wrap modulo DEPTH; count is PTR_W+1 bits.
- Write accept:
  - cpu_data_addr_ok = cpu_data_req & cpu_data_wr & ~full & ~rd_busy; push on the same edge.
  - cpu_data_data_ok pulses exactly one cycle later (registered).
  - rd_busy = FSM in RD_REQ or RD_WAIT.
  - When full, addr_ok stays 0 until a pop frees an entry; the accept can occur in the cycle after the pop.
- Read eligibility: read eligible = cpu_data_req & ~cpu_data_wr & FSM in IDLE & hazard-free.
  - Hazard-free = buffer empty (see optional feature).
  - cpu_data_addr_ok asserts in the eligible cycle; addr and size are latched.
- Downstream FSM: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - IDLE -> RD_REQ: read eligible. Reads have priority over drain.
  - IDLE -> WR_REQ: otherwise, if the buffer is non-empty.
  - RD_REQ: mem_data_req=1, wr=0, latched addr/size; goes to RD_WAIT on mem_data_addr_ok.
  - RD_WAIT: on mem_data_data_ok, cpu_data_data_ok=1 and cpu_data_rdata=mem_data_rdata in the same cycle (combinational); then IDLE.
  - WR_REQ: mem_data_req=1, wr=1, addr/size/wdata taken from the head entry; goes to WR_WAIT on mem_data_addr_ok.
  - WR_WAIT: on mem_data_data_ok, pop the head and return to IDLE.
- mem_data_req is asserted only in RD_REQ and WR_REQ. At most one downstream transaction is outstanding.
- A push and a pop in the same cycle leave count unchanged. Pointers wrap from DEPTH-1 to 0.
- Entries drain in FIFO order and are never merged or dropped.
- Reset, including mid-transaction:
  - FSM to IDLE, pointers and count to 0, valid bits cleared, buffered data discarded.
  - All outputs 0, except wbuf_empty=1.
  - The downstream bridge must be reset together with this block.
- cpu_data_rdata is 0 whenever cpu_data_data_ok is not asserted for a read.

Optional Feature:
- Macro: WBUF_RAW_BYPASS_EN.
- Defined:
  - Hazard-free = no valid entry whose addr[31:2] equals cpu_data_addr[31:2].
  - Non-matching reads overtake buffered writes, so a refill after a dirty eviction proceeds immediately.
  - Matching reads wait until the matching entries drain.
- Undefined: hazard-free = buffer empty; every read waits for a full drain.

Test Plan:
- Single write 0x1000_0040 / 0xDEAD_BEEF: addr_ok in the request cycle, data_ok the next cycle; downstream write appears within 2 cycles with the same addr, data and size; wbuf_empty returns to 1 after mem data_ok.
- Fill DEPTH=4 with a downstream addr_ok held low: 4 accepts, the 5th is held with addr_ok=0; releasing the downstream pops entry 0, and the 5th is accepted after that pop; 5 writes exit in order.
- Write to 0x100, then read 0x200 with the downstream stalled:
  - with the macro: the read is issued before the write;
  - without it: the write is issued first.
  - Either way read data equals mem_data_rdata on the data_ok cycle.
- Write to 0x100, then read 0x100 (macro defined): the read is not accepted until the write's mem data_ok; the write appears downstream before the read.
- Simultaneous push and pop at count=2: count stays 2; pointer wrap verified over 10 writes.
- Assert resetn low during WR_WAIT with 3 entries buffered: all outputs 0 and wbuf_empty=1 immediately; after release, no stale writes are issued.
